control_sequencer: RTL and testbench

//  Hardwired control unit that drives the Datapath strobes.

---
 rtl/control_sequencer.sv | 158 +++++++++++++++
 tb/tb_control_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired step sequencer that fetches and executes one instruction at a time,
// driving the Datapath bus/load strobes as a Moore decode of {state, wait count, opcode}.
module control_sequencer #(
  parameter int MEM_LAT = 1,
  parameter int IR_W    = 32,
  parameter int OPC_LSB = 27
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            run,
  input  logic [IR_W-1:0] IR,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Cout,
  output logic            BAout,
  output logic            Rout,
  output logic            PCin,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Rin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic [3:0]      alu_op,
  output logic [3:0]      step,
  output logic            instr_done,
  output logic            halted
);

  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_IDLE = 4'd8, S_HALT = 4'd9
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;

  logic [4:0] opc;
  logic       is_ld, is_st, is_mem, is_r, is_imm, is_un, is_halt;
  logic [3:0] op_alu;
  logic       first_cyc, last_cyc;
  logic       unused_ir;

  assign opc     = IR[OPC_LSB+4:OPC_LSB];
  assign is_ld   = (opc == 5'd0);
  assign is_st   = (opc == 5'd2);
  assign is_mem  = (opc <= 5'd2);
  assign is_r    = (opc >= 5'd3)  && (opc <= 5'd10);
  assign is_imm  = (opc >= 5'd11) && (opc <= 5'd13);
  assign is_un   = (opc == 5'd14) || (opc == 5'd15);
  assign is_halt = (opc == 5'd27);
  assign unused_ir = ^IR;

  // R-type opcodes 3..10 map straight onto ALU codes 1..8.
  always_comb begin
    op_alu = 4'd0;
    if (is_r)             op_alu = 4'(opc - 5'd2);
    else if (opc == 5'd11) op_alu = 4'd1;
    else if (opc == 5'd12) op_alu = 4'd3;
    else if (opc == 5'd13) op_alu = 4'd4;
    else if (opc == 5'd14) op_alu = 4'd9;
    else if (opc == 5'd15) op_alu = 4'd10;
  end

  assign first_cyc = (wait_q == LAT);
  assign last_cyc  = (wait_q == 4'd0);

  always_comb begin
    {PCout, Zlowout, MDRout, Cout, BAout, Rout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zin, Rin}   = '0;
    {Gra, Grb, Grc, IncPC, Read, Write}         = '0;
    alu_op     = 4'd0;
    instr_done = 1'b0;
    halted     = (state_q == S_HALT);
    step       = (state_q == S_IDLE || state_q == S_HALT) ? 4'd0 : 4'(state_q);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin
        Read = 1'b1; MDRin = 1'b1;
        if (first_cyc) begin Zlowout = 1'b1; PCin = 1'b1; end
      end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_mem) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else if (is_r || is_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_un) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_alu; end
        else if (!is_halt) instr_done = 1'b1;
      end
      S_T4: begin
        if (is_mem) begin Cout = 1'b1; Zin = 1'b1; alu_op = 4'd1; end
        else if (is_r) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_alu; end
        else if (is_imm) begin Cout = 1'b1; Zin = 1'b1; alu_op = op_alu; end
        else begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_ld || is_st) MARin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
      end
      S_T6: begin
        if (is_ld) begin Read = 1'b1; MDRin = 1'b1; end
        else begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      end
      S_T7: begin
        if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
        else begin Write = 1'b1; instr_done = last_cyc; end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   begin state_d = S_T1; wait_d = LAT; end
      S_T1:   if (!last_cyc) wait_d = 4'(wait_q - 4'd1); else state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = is_halt ? S_HALT : S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   begin state_d = S_T6; wait_d = LAT; end
      S_T6: begin
        if (is_ld && !last_cyc) wait_d = 4'(wait_q - 4'd1);
        else begin state_d = S_T7; wait_d = is_st ? LAT : 4'd0; end
      end
      S_T7:   if (!last_cyc) wait_d = 4'(wait_q - 4'd1);
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // run is only looked at when an instruction retires (or in IDLE above).
    if (instr_done) begin
      state_d = run ? S_T0 : S_IDLE;
      wait_d  = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: one sequencer with zero memory latency, one with two wait cycles;
// every cycle of each instruction is compared against a hand-written strobe table.
module tb_control_sequencer;

  logic        clk, clear, run0, run2;
  logic [31:0] ir0, ir2;
  logic [19:0] s0, s2;
  logic [3:0]  a0, a2, t0, t2;
  logic        h0, h2;
  logic [28:0] o0, o2;

  assign o0 = {t0, a0, h0, s0};
  assign o2 = {t2, a2, h2, s2};

  localparam logic [19:0] PCOUT = 20'h80000, ZLO = 20'h40000, MDRO = 20'h20000,
    COUT = 20'h10000, BAO = 20'h08000, ROUT = 20'h04000, PCIN = 20'h02000,
    MARIN = 20'h01000, MDRIN = 20'h00800, IRIN = 20'h00400, YIN = 20'h00200,
    ZIN = 20'h00100, RIN = 20'h00080, GRA = 20'h00040, GRB = 20'h00020,
    GRC = 20'h00010, INC = 20'h00008, RD = 20'h00004, WR = 20'h00002, DONE = 20'h00001;

  control_sequencer #(.MEM_LAT(0), .IR_W(32), .OPC_LSB(27)) u0 (
    .clk(clk), .clear(clear), .run(run0), .IR(ir0),
    .PCout(s0[19]), .Zlowout(s0[18]), .MDRout(s0[17]), .Cout(s0[16]), .BAout(s0[15]),
    .Rout(s0[14]), .PCin(s0[13]), .MARin(s0[12]), .MDRin(s0[11]), .IRin(s0[10]),
    .Yin(s0[9]), .Zin(s0[8]), .Rin(s0[7]), .Gra(s0[6]), .Grb(s0[5]), .Grc(s0[4]),
    .IncPC(s0[3]), .Read(s0[2]), .Write(s0[1]), .alu_op(a0), .step(t0),
    .instr_done(s0[0]), .halted(h0));

  control_sequencer #(.MEM_LAT(2), .IR_W(32), .OPC_LSB(27)) u2 (
    .clk(clk), .clear(clear), .run(run2), .IR(ir2),
    .PCout(s2[19]), .Zlowout(s2[18]), .MDRout(s2[17]), .Cout(s2[16]), .BAout(s2[15]),
    .Rout(s2[14]), .PCin(s2[13]), .MARin(s2[12]), .MDRin(s2[11]), .IRin(s2[10]),
    .Yin(s2[9]), .Zin(s2[8]), .Rin(s2[7]), .Gra(s2[6]), .Grb(s2[5]), .Grc(s2[4]),
    .IncPC(s2[3]), .Read(s2[2]), .Write(s2[1]), .alu_op(a2), .step(t2),
    .instr_done(s2[0]), .halted(h2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  logic [28:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic add(input logic [3:0] st, input logic [3:0] alu, input logic [19:0] s);
    exp_q.push_back({st, alu, 1'b0, s});
  endtask

  task automatic fetch(input int lat);
    add(0, 0, PCOUT | MARIN | INC | ZIN);
    add(1, 0, ZLO | PCIN | RD | MDRIN);
    repeat (lat) add(1, 0, RD | MDRIN);
    add(2, 0, MDRO | IRIN);
  endtask

  task automatic ldi_seq();
    fetch(0);
    add(3, 0, GRB | BAO | YIN);
    add(4, 1, COUT | ZIN);
    add(5, 0, ZLO | GRA | RIN | DONE);
  endtask

  // Walk the expected table one clock per entry; run is dropped after entry 'drop'.
  task automatic play(input bit sel, input int drop, input string tag);
    logic [28:0] obs;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      obs = sel ? o2 : o0;
      chk($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(exp_q[i]));
      chk($sformatf("%s[%0d]_bus", tag, i), 32'($countones(obs[19:14]) <= 1), 32'd1);
      if (i == drop) begin
        if (sel) run2 = 1'b0; else run0 = 1'b0;
      end
    end
    exp_q.delete();
  endtask

  initial begin
    clear = 1'b0; run0 = 1'b0; run2 = 1'b0; ir0 = '0; ir2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_u0", 32'(o0), 32'd0);
    chk("reset_u2", 32'(o2), 32'd0);
    clear = 1'b1;

    // ldi interrupted by reset in T4
    ir0 = 32'h0880_0085; run0 = 1'b1;
    fetch(0);
    add(3, 0, GRB | BAO | YIN);
    add(4, 1, COUT | ZIN);
    play(0, -1, "ldi_pre_clr");
    clear = 1'b0; #1;
    chk("async_clear", 32'(o0), 32'd0);
    @(posedge clk); #1;
    chk("held_in_reset", 32'(o0), 32'd0);
    clear = 1'b1;

    // three ldi back to back, run dropped inside the last one
    ldi_seq(); ldi_seq(); ldi_seq();
    play(0, 16, "ldi_b2b");
    @(posedge clk); #1;
    chk("ldi_idle_after", 32'(o0), 32'd0);

    // ld with two extra memory wait cycles
    ir2 = 32'h0080_0010; run2 = 1'b1;
    fetch(2);
    add(3, 0, GRB | BAO | YIN);
    add(4, 1, COUT | ZIN);
    add(5, 0, ZLO | MARIN);
    repeat (3) add(6, 0, RD | MDRIN);
    add(7, 0, MDRO | GRA | RIN | DONE);
    play(1, 0, "ld_lat2");
    @(posedge clk); #1;
    chk("ld_idle_after", 32'(o2), 32'd0);

    // st with two extra memory wait cycles
    ir2 = 32'h1000_0000; run2 = 1'b1;
    fetch(2);
    add(3, 0, GRB | BAO | YIN);
    add(4, 1, COUT | ZIN);
    add(5, 0, ZLO | MARIN);
    add(6, 0, GRA | ROUT | MDRIN);
    add(7, 0, WR); add(7, 0, WR); add(7, 0, WR | DONE);
    play(1, 0, "st_lat2");
    @(posedge clk); #1;
    chk("st_idle_after", 32'(o2), 32'd0);

    // sub followed directly by halt
    ir0 = 32'h2000_0000; run0 = 1'b1;
    fetch(0);
    add(3, 0, GRB | ROUT | YIN);
    add(4, 2, GRC | ROUT | ZIN);
    add(5, 0, ZLO | GRA | RIN | DONE);
    play(0, -1, "sub");
    ir0 = 32'hD800_0000;
    fetch(0);
    add(3, 0, 20'd0);
    play(0, -1, "halt_fetch");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("halted[%0d]", i), 32'(o0), 32'({4'd0, 4'd0, 1'b1, 20'd0}));
    end
    run0 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
